div_unit: RTL

- Multi-cycle 32/32 integer divider in the execute stage.
- Consumes the two operands read from the register file (rdata1 = dividend, rdata2 = divisor) and produces a 64-bit {remainder, quotient}.
- The result is written to HI/LO by the downstream write-back path.
- Radix-2 restoring algorithm, one quotient bit per cycle; the EX stage stalls on ready_o.

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM states, handshake levels
// and bus widths.
package div_unit_pkg;

    localparam int REG_W        = 32;
    localparam int DOUBLE_REG_W = 64;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    localparam logic RST_ENABLE           = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    function automatic logic [REG_W-1:0] twos_neg(input logic [REG_W-1:0] v);
        return ~v + {{(REG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring 32/32 divider producing {remainder, quotient}.
// Optional macro DIV_FAST_ZERO_EN finishes a zero dividend without iterating.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ITER   = REG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [DATA_W-1:0]       opdata1_i,
    input  logic [DATA_W-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DOUBLE_REG_W-1:0] result_o,
    output logic                    ready_o
);

    localparam int CNT_W = $clog2(ITER);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  dividend;
    logic [DATA_W-1:0]  divisor;
    logic [DATA_W-1:0]  rem;
    logic [DATA_W-1:0]  quo;
    logic               neg_quo;
    logic               neg_rem;

    logic [DATA_W:0]    trial;
    logic [DATA_W-1:0]  rem_nxt;
    logic [DATA_W-1:0]  quo_nxt;

    // One restoring step: a borrow out of the 33-bit trial means the divisor did not fit.
    always_comb begin
        trial   = {rem, dividend[DATA_W-1]} - {1'b0, divisor};
        rem_nxt = {rem[DATA_W-2:0], dividend[DATA_W-1]};
        quo_nxt = {quo[DATA_W-2:0], 1'b0};
        if (!trial[DATA_W]) begin
            rem_nxt = trial[DATA_W-1:0];
            quo_nxt = {quo[DATA_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        // Iterate on magnitudes and remember which results need negating.
                        dividend <= (signed_div_i && opdata1_i[DATA_W-1]) ? twos_neg(opdata1_i) : opdata1_i;
                        divisor  <= (signed_div_i && opdata2_i[DATA_W-1]) ? twos_neg(opdata2_i) : opdata2_i;
                        neg_quo  <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem  <= signed_div_i && opdata1_i[DATA_W-1];
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        if (opdata2_i == ZERO_WORD) begin
                            state <= DIV_BY_ZERO;
                        end
`ifdef DIV_FAST_ZERO_EN
                        else if (opdata1_i == ZERO_WORD) begin
                            state <= DIV_END;
                        end
`endif
                        else begin
                            state <= DIV_ON;
                        end
                    end
                end

                DIV_BY_ZERO: begin
                    state <= annul_i ? DIV_FREE : DIV_END;
                end

                DIV_ON: begin
                    if (annul_i) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end else begin
                        dividend <= {dividend[DATA_W-2:0], 1'b0};
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ITER - 1)) begin
                            state <= DIV_END;
                            quo   <= neg_quo ? twos_neg(quo_nxt) : quo_nxt;
                            rem   <= neg_rem ? twos_neg(rem_nxt) : rem_nxt;
                        end else begin
                            quo   <= quo_nxt;
                            rem   <= rem_nxt;
                        end
                    end
                end

                DIV_END: begin
                    // The result is presented one edge after entry and held until EX releases start.
                    if (start_i == DIV_START) begin
                        result_o <= {rem, quo};
                        ready_o  <= DIV_RESULT_READY;
                    end else begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end

                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
